// File: rtl/xgmii_pkg.sv
// Shared constants and FSM state type for the XGMII frame generator.
package xgmii_pkg;

    localparam logic [7:0]  XGMII_IDLE  = 8'h07;
    localparam logic [7:0]  XGMII_START = 8'hFB;
    localparam logic [7:0]  XGMII_TERM  = 8'hFD;
    localparam logic [7:0]  XGMII_ERROR = 8'hFE;
    localparam logic [7:0]  PREAMBLE    = 8'h55;
    localparam logic [7:0]  SFD         = 8'hD5;

    localparam logic [63:0] IDLE_WORD   = {8{XGMII_IDLE}};
    localparam logic [63:0] START_WORD  = {SFD, {6{PREAMBLE}}, XGMII_START};

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_PAYLOAD,
        ST_TERM,
        ST_IPG
    } state_e;

endpackage

// File: rtl/xgmii_frame_gen_if.sv
// XGMII TX data/control bus between the frame generator and the PCS encoder.
interface xgmii_frame_gen_if #(
    parameter int DATA_WIDTH = 64,
    parameter int CTRL_WIDTH = DATA_WIDTH / 8
);
    logic [DATA_WIDTH-1:0] xgmii_txd;
    logic [CTRL_WIDTH-1:0] xgmii_txc;

    modport master (output xgmii_txd, output xgmii_txc);
    modport slave  (input  xgmii_txd, input  xgmii_txc);
endinterface

// File: rtl/xgmii_term_word.sv
// Builds the terminate word: r trailing data bytes, then 0xFD, then idle fill.
module xgmii_term_word
    import xgmii_pkg::*;
(
    input  logic [2:0]  r,
    input  logic [7:0]  start_byte,
    input  logic        err,
    output logic [63:0] txd,
    output logic [7:0]  txc
);

    // Lanes below r carry the tail of the payload; an error replaces lane 0 only if it holds data
    always_comb begin
        txd = IDLE_WORD;
        txc = 8'hFF << r;
        for (int j = 0; j < 8; j++) begin
            if (3'(j) < r) begin
                txd[8*j +: 8] = start_byte + 8'(j);
            end else if (3'(j) == r) begin
                txd[8*j +: 8] = XGMII_TERM;
            end
        end
        if (err && (r != 3'd0)) begin
            txd[7:0] = XGMII_ERROR;
            txc[0]   = 1'b1;
        end
    end

endmodule

// File: rtl/xgmii_frame_gen.sv
// Deterministic XGMII frame generator: START, counting-byte payload, TERM, IPG.
module xgmii_frame_gen
    import xgmii_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int CTRL_WIDTH = DATA_WIDTH / 8
) (
    input  logic                tx_clk,
    input  logic                tx_rst_n,
    input  logic                enable,
    input  logic [10:0]         cfg_frame_len,
    input  logic [3:0]          cfg_ipg,
    input  logic [15:0]         cfg_frame_limit,
    input  logic                inject_err,
    xgmii_frame_gen_if.master   tx,
    output logic                busy,
    output logic                done,
    output logic [15:0]         frame_count
);

    state_e                 state_q, state_d;
    logic [7:0]             cnt_q, cnt_d;
    logic [10:0]            len_q, len_d;
    logic [3:0]             ipg_q, ipg_d;
    logic [15:0]            limit_q, limit_d;
    logic [DATA_WIDTH-1:0]  txd_q, txd_d;
    logic [CTRL_WIDTH-1:0]  txc_q, txc_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic [15:0]            frame_count_q, frame_count_d;
    logic                   err_q, err_d;

    logic [7:0]             words;
    logic [2:0]             rem;
    logic                   limit_hit;
    logic                   err_use;
    logic [7:0]             pay_base;
    logic [7:0]             term_base;
    logic [63:0]            term_txd;
    logic [7:0]             term_txc;

    assign words     = len_q[10:3];
    assign rem       = len_q[2:0];
    assign limit_hit = (limit_q != 16'd0) && (frame_count_q >= limit_q);
    assign pay_base  = frame_count_q[7:0] + {cnt_q[4:0], 3'b000};
    assign term_base = frame_count_q[7:0] + {len_q[7:3], 3'b000};

    xgmii_term_word u_term (
        .r          (rem),
        .start_byte (term_base),
        .err        (err_q),
        .txd        (term_txd),
        .txc        (term_txc)
    );

    // State, counters, latched config and registered outputs
    always_ff @(posedge tx_clk) begin
        if (!tx_rst_n) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            len_q         <= 11'd1;
            ipg_q         <= 4'd1;
            limit_q       <= '0;
            txd_q         <= IDLE_WORD;
            txc_q         <= '1;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            frame_count_q <= '0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            len_q         <= len_d;
            ipg_q         <= ipg_d;
            limit_q       <= limit_d;
            txd_q         <= txd_d;
            txc_q         <= txc_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            frame_count_q <= frame_count_d;
            err_q         <= err_d;
        end
    end

    // Next state; config is captured whenever a frame is about to start
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        ipg_d   = ipg_q;
        limit_d = limit_q;
        case (state_q)
            ST_IDLE: begin
                if (enable && !done_q) state_d = ST_START;
            end
            ST_START: begin
                cnt_d   = '0;
                state_d = (words != 8'd0) ? ST_PAYLOAD : ST_TERM;
            end
            ST_PAYLOAD: begin
                if (cnt_q == words - 8'd1) begin
                    cnt_d   = '0;
                    state_d = ST_TERM;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_TERM: begin
                cnt_d   = '0;
                state_d = ST_IPG;
            end
            ST_IPG: begin
                if (cnt_q == {4'd0, ipg_q} - 8'd1) begin
                    cnt_d   = '0;
                    state_d = (enable && !limit_hit) ? ST_START : ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (state_d == ST_START) begin
            len_d   = (cfg_frame_len == 11'd0) ? 11'd1 : cfg_frame_len;
            ipg_d   = (cfg_ipg == 4'd0) ? 4'd1 : cfg_ipg;
            limit_d = cfg_frame_limit;
        end
    end

    // Word to register for the current state, plus status and error-flag bookkeeping
    always_comb begin
        txd_d         = IDLE_WORD;
        txc_d         = '1;
        busy_d        = (state_q != ST_IDLE);
        frame_count_d = frame_count_q;
        err_use       = 1'b0;
        case (state_q)
            ST_START: begin
                txd_d = START_WORD;
                txc_d = 8'h01;
            end
            ST_PAYLOAD: begin
                for (int j = 0; j < 8; j++) begin
                    txd_d[8*j +: 8] = pay_base + 8'(j);
                end
                txc_d = 8'h00;
                if (err_q) begin
                    txd_d[7:0] = XGMII_ERROR;
                    txc_d[0]   = 1'b1;
                    err_use    = 1'b1;
                end
            end
            ST_TERM: begin
                txd_d         = term_txd;
                txc_d         = term_txc;
                frame_count_d = frame_count_q + 16'd1;
                err_use       = err_q && (rem != 3'd0);
            end
            default: ;
        endcase
        err_d  = err_q ? !err_use : inject_err;
        done_d = done_q;
        if ((state_q == ST_IPG) && limit_hit) done_d = 1'b1;
        if (!enable) done_d = 1'b0;
    end

    assign tx.xgmii_txd = txd_q;
    assign tx.xgmii_txc = txc_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign frame_count  = frame_count_q;

endmodule

// File: tb/tb_xgmii_frame_gen.sv
// Self-checking bench for xgmii_frame_gen: byte-stream model feeding a per-cycle scoreboard.
module tb_xgmii_frame_gen;

    logic        tx_clk = 1'b0;
    logic        tx_rst_n;
    logic        enable;
    logic [10:0] cfg_frame_len;
    logic [3:0]  cfg_ipg;
    logic [15:0] cfg_frame_limit;
    logic        inject_err;
    logic        busy;
    logic        done;
    logic [15:0] frame_count;

    xgmii_frame_gen_if txif ();

    xgmii_frame_gen dut (
        .tx_clk          (tx_clk),
        .tx_rst_n        (tx_rst_n),
        .enable          (enable),
        .cfg_frame_len   (cfg_frame_len),
        .cfg_ipg         (cfg_ipg),
        .cfg_frame_limit (cfg_frame_limit),
        .inject_err      (inject_err),
        .tx              (txif),
        .busy            (busy),
        .done            (done),
        .frame_count     (frame_count)
    );

    // 100 MHz TX clock
    always #5 tx_clk = ~tx_clk;

    localparam logic [63:0] IDLE_W  = 64'h0707070707070707;
    localparam logic [63:0] START_W = 64'hD5555555555555FB;

    typedef struct {
        logic [63:0] d;
        logic [7:0]  c;
        logic        b;
        logic        dn;
        logic [15:0] fc;
    } exp_t;

    exp_t        exp_q[$];
    int          vectors = 0;
    int          miscompares = 0;

    int          m_fc = 0;
    bit          m_done = 1'b0;
    bit          m_err = 1'b0;
    logic [63:0] last_first_data;
    logic [7:0]  last_first_ctrl;
    logic [63:0] last_term_d;
    logic [7:0]  last_term_c;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
        end
    endtask

    task automatic applyStimulus(input int len, input int ipg, input int limit, input logic en);
        cfg_frame_len   = 11'(len);
        cfg_ipg         = 4'(ipg);
        cfg_frame_limit = 16'(limit);
        enable          = en;
    endtask

    task automatic push_word(input logic [63:0] d, input logic [7:0] c, input logic b);
        exp_t e;
        e.d  = d;
        e.c  = c;
        e.b  = b;
        e.dn = m_done;
        e.fc = 16'(m_fc);
        exp_q.push_back(e);
    endtask

    task automatic push_idle(input logic b);
        push_word(IDLE_W, 8'hFF, b);
    endtask

    // Expected output stream of one whole frame, built from the byte-level framing rules
    task automatic model_frame(input int len, input int ipg, input int limit);
        int          l;
        int          g;
        int          f;
        int          n;
        int          rem;
        bit          first;
        logic [63:0] d;
        logic [7:0]  c;
        l     = (len == 0) ? 1 : len;
        g     = (ipg == 0) ? 1 : ipg;
        f     = m_fc % 256;
        n     = 0;
        first = 1'b1;
        last_first_data = '0;
        last_first_ctrl = '0;
        push_word(START_W, 8'h01, 1'b1);
        while (n + 8 <= l) begin
            for (int j = 0; j < 8; j++) d[8*j +: 8] = 8'((f + n + j) % 256);
            c = 8'h00;
            if (m_err) begin
                d[7:0] = 8'hFE;
                c[0]   = 1'b1;
                m_err  = 1'b0;
            end
            if (first) begin
                last_first_data = d;
                last_first_ctrl = c;
                first = 1'b0;
            end
            push_word(d, c, 1'b1);
            n += 8;
        end
        rem = l - n;
        for (int j = 0; j < 8; j++) begin
            if (j < rem) begin
                d[8*j +: 8] = 8'((f + n + j) % 256);
                c[j] = 1'b0;
            end else if (j == rem) begin
                d[8*j +: 8] = 8'hFD;
                c[j] = 1'b1;
            end else begin
                d[8*j +: 8] = 8'h07;
                c[j] = 1'b1;
            end
        end
        if (m_err && rem > 0) begin
            d[7:0] = 8'hFE;
            c[0]   = 1'b1;
            m_err  = 1'b0;
        end
        m_fc = (m_fc + 1) % 65536;
        last_term_d = d;
        last_term_c = c;
        push_word(d, c, 1'b1);
        if (limit != 0 && m_fc >= limit) m_done = 1'b1;
        repeat (g) push_idle(1'b1);
    endtask

    task automatic wait_queue(input int left, input string tag);
        int budget;
        budget = 3000;
        while (exp_q.size() > left && budget > 0) begin
            @(negedge tx_clk);
            budget--;
        end
        if (exp_q.size() > left) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL %s timeout: %0d entries left, expected <= %0d", tag, exp_q.size(), left);
            exp_q.delete();
        end
    endtask

    task automatic do_reset();
        @(negedge tx_clk);
        tx_rst_n   = 1'b0;
        inject_err = 1'b0;
        applyStimulus(1, 1, 0, 1'b0);
        exp_q.delete();
        repeat (2) @(negedge tx_clk);
        tx_rst_n = 1'b1;
        m_fc     = 0;
        m_done   = 1'b0;
        m_err    = 1'b0;
    endtask

    // Scoreboard: one expected entry per clock, sampled just after the active edge
    initial begin
        exp_t cur;
        forever begin
            @(posedge tx_clk);
            #1;
            if (exp_q.size() > 0) begin
                cur = exp_q.pop_front();
                checkOutput("txd",         txif.xgmii_txd,      cur.d);
                checkOutput("txc",         64'(txif.xgmii_txc), 64'(cur.c));
                checkOutput("busy",        64'(busy),           64'(cur.b));
                checkOutput("done",        64'(done),           64'(cur.dn));
                checkOutput("frame_count", 64'(frame_count),    64'(cur.fc));
            end
        end
    end

    // Global time bound
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, %0d entries pending", exp_q.size());
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        tx_rst_n   = 1'b0;
        inject_err = 1'b0;
        applyStimulus(1, 1, 0, 1'b0);
        repeat (2) @(negedge tx_clk);
        checkOutput("rst_txd",  txif.xgmii_txd,      IDLE_W);
        checkOutput("rst_txc",  64'(txif.xgmii_txc), 64'hFF);
        checkOutput("rst_busy", 64'(busy),           64'd0);
        checkOutput("rst_done", 64'(done),           64'd0);
        checkOutput("rst_fc",   64'(frame_count),    64'd0);
        do_reset();

        $display("[TB] single frame L=16 ipg=2 limit=1");
        applyStimulus(16, 2, 1, 1'b1);
        push_idle(1'b0);
        model_frame(16, 2, 1);
        checkOutput("pinA_data0", last_first_data, 64'h0706050403020100);
        checkOutput("pinA_ctrl0", 64'(last_first_ctrl), 64'h00);
        checkOutput("pinA_term",  last_term_d, 64'h07070707070707FD);
        checkOutput("pinA_termc", 64'(last_term_c), 64'hFF);
        push_idle(1'b0);
        push_idle(1'b0);
        wait_queue(0, "A");
        checkOutput("A_done", 64'(done), 64'd1);
        checkOutput("A_fc",   64'(frame_count), 64'd1);
        enable = 1'b0;
        m_done = 1'b0;
        push_idle(1'b0);
        wait_queue(0, "A_clr");

        $display("[TB] two frames L=13 ipg=3 limit=2");
        do_reset();
        applyStimulus(13, 3, 2, 1'b1);
        push_idle(1'b0);
        model_frame(13, 3, 2);
        model_frame(13, 3, 2);
        checkOutput("pinB_data", last_first_data, 64'h0807060504030201);
        checkOutput("pinB_term", last_term_d, 64'h0707FD0D0C0B0A09);
        checkOutput("pinB_termc", 64'(last_term_c), 64'hE0);
        push_idle(1'b0);
        wait_queue(0, "B");
        enable = 1'b0;
        m_done = 1'b0;
        push_idle(1'b0);
        wait_queue(0, "B_clr");

        $display("[TB] error injection in IDLE, L=8");
        do_reset();
        inject_err = 1'b1;
        m_err = 1'b1;
        push_idle(1'b0);
        @(negedge tx_clk);
        inject_err = 1'b0;
        applyStimulus(8, 1, 2, 1'b1);
        push_idle(1'b0);
        model_frame(8, 1, 2);
        checkOutput("pinD_err",  last_first_data, 64'h07060504030201FE);
        checkOutput("pinD_errc", 64'(last_first_ctrl), 64'h01);
        model_frame(8, 1, 2);
        checkOutput("pinD_clean", last_first_data, 64'h0807060504030201);
        push_idle(1'b0);
        wait_queue(0, "D");
        enable = 1'b0;
        m_done = 1'b0;
        push_idle(1'b0);
        wait_queue(0, "D_clr");

        $display("[TB] error injection landing in TERM, L=3");
        inject_err = 1'b1;
        m_err = 1'b1;
        push_idle(1'b0);
        @(negedge tx_clk);
        inject_err = 1'b0;
        applyStimulus(3, 1, 3, 1'b1);
        push_idle(1'b0);
        model_frame(3, 1, 3);
        checkOutput("pinD2_term",  last_term_d, 64'h07070707FD0403FE);
        checkOutput("pinD2_termc", 64'(last_term_c), 64'hF9);
        push_idle(1'b0);
        wait_queue(0, "D2");
        enable = 1'b0;
        m_done = 1'b0;
        push_idle(1'b0);
        wait_queue(0, "D2_clr");

        $display("[TB] continuous L=3 ipg=1");
        do_reset();
        applyStimulus(3, 1, 0, 1'b1);
        push_idle(1'b0);
        model_frame(3, 1, 0);
        checkOutput("pinC_term0", last_term_d, 64'h07070707FD020100);
        checkOutput("pinC_termc", 64'(last_term_c), 64'hF8);
        model_frame(3, 1, 0);
        checkOutput("pinC_term1", last_term_d, 64'h07070707FD030201);
        model_frame(3, 1, 0);
        wait_queue(2, "C_run");
        enable = 1'b0;
        push_idle(1'b0);
        wait_queue(0, "C");
        checkOutput("C_done", 64'(done), 64'd0);
        checkOutput("C_fc",   64'(frame_count), 64'd3);

        $display("[TB] enable dropped mid-payload, L=64");
        applyStimulus(64, 2, 0, 1'b1);
        push_idle(1'b0);
        model_frame(64, 2, 0);
        wait_queue(7, "E_run");
        enable = 1'b0;
        push_idle(1'b0);
        push_idle(1'b0);
        wait_queue(0, "E");
        checkOutput("E_busy", 64'(busy), 64'd0);

        $display("[TB] reset mid-frame");
        applyStimulus(64, 1, 0, 1'b1);
        push_idle(1'b0);
        model_frame(64, 1, 0);
        wait_queue(8, "F_run");
        tx_rst_n = 1'b0;
        enable   = 1'b0;
        exp_q.delete();
        m_fc   = 0;
        m_err  = 1'b0;
        m_done = 1'b0;
        push_idle(1'b0);
        @(negedge tx_clk);
        tx_rst_n = 1'b1;
        applyStimulus(16, 1, 0, 1'b1);
        push_idle(1'b0);
        model_frame(16, 1, 0);
        checkOutput("pinF_data0", last_first_data, 64'h0706050403020100);
        wait_queue(2, "F_restart");
        enable = 1'b0;
        push_idle(1'b0);
        wait_queue(0, "F");
        checkOutput("F_fc", 64'(frame_count), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
